fib_seq_ctrl: RTL and testbench

FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

---
 rtl/fib_pkg.sv | 17 +
 rtl/fib_seq_ctrl.sv | 114 +++++++++++
 tb/tb_fib_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared constants and FSM state encoding for the Fibonacci sequence controller.
// Holds the default RAM address/data widths and the controller state enum.
package fib_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_CAP_B = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequence controller: reads two operands from an external RAM,
// writes their sum two words on, and repeats len times starting at base.
// Ports: clk, rst (sync, active-high), start/base/len request,
//        busy/done/ovf status, ram_addr/ram_we/ram_wdata/ram_rdata RAM port,
//        data1/data2 last captured operands A and B.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              ovf_q;

    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] cnt_nxt;

    // Extra top bit of the sum is the carry-out used for overflow.
    assign sum     = {1'b0, op_a} + {1'b0, op_b};
    assign cnt_nxt = cnt + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
            len_q <= '0;
            op_a  <= '0;
            op_b  <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= base;
                        len_q <= len;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        state <= (len == '0) ? ST_DONE : ST_RD_A;
                    end
                end
                ST_RD_A: state <= ST_RD_B;
                ST_RD_B: begin
                    // Read of idx issued in RD_A lands now.
                    op_a  <= ram_rdata;
                    state <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    op_b  <= ram_rdata;
                    state <= ST_WR;
                end
                ST_WR: begin
                    cnt <= cnt_nxt;
                    if (sum[DATA_W]) ovf_q <= 1'b1;
                    if (cnt_nxt == len_q) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= ST_RD_A;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state; rst gates the strobes so a reset landing
    // in WR or DONE neither writes nor reports completion.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            ST_RD_A: ram_addr = idx;
            ST_RD_B: ram_addr = idx + ADDR_W'(1);
            ST_WR: begin
                ram_addr  = idx + ADDR_W'(2);
                ram_we    = !rst;
                ram_wdata = rst ? '0 : sum[DATA_W-1:0];
            end
            ST_DONE: done = !rst;
            default: ;
        endcase
    end

    assign ovf   = ovf_q;
    assign data1 = op_a;
    assign data2 = op_b;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a single-port synchronous-read RAM.
// The RAM also exposes a load port and a combinational peek for the bench.
module ram_sp #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] pk_addr,
    output logic [DATA_W-1:0] pk_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        else if (ld_en) mem[ld_addr] <= ld_data;
        rdata <= mem[addr];
    end

    assign pk_data = mem[pk_addr];
endmodule

module tb_fib_seq_ctrl;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] len = '0;
    logic          busy, done, ovf, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, data1, data2;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [AW-1:0] pk_addr = '0;
    logic [DW-1:0] pk_data;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int e_cyc = 0;
    int done_n = 0;
    int done_cyc = 0;
    int wr_n = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .ovf(ovf),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .data1(data1), .data2(data2)
    );

    ram_sp #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk(clk), .addr(ram_addr), .we(ram_we), .wdata(ram_wdata),
        .rdata(ram_rdata), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .pk_addr(pk_addr), .pk_data(pk_data)
    );

    // Observe the cycle that the edge closes: done_cyc - e_cyc == 4*len.
    always @(posedge clk) begin
        if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
        if (ram_we) wr_n = wr_n + 1;
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [AW-1:0] a,
                        input logic [DW-1:0] exp);
        pk_addr = a;
        #1;
        chk(tag, pk_data, exp);
    endtask

    // Leaves the bench at the negedge of cycle E+1 with e_cyc recorded.
    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(negedge clk);
        done_n = 0; wr_n = 0; done_cyc = -1;
        start = 1'b1; base = b; len = l;
        @(negedge clk);
        start = 1'b0;
        e_cyc = cyc;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k = k + 1;
        end
        if (busy) chk("timeout", 32'(busy), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_d1"}, data1, 32'd0);
        chk({tag, "_d2"}, data2, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp_seq [8];
        exp_seq = '{32'd4, 32'd6, 32'd10, 32'd16,
                    32'd26, 32'd42, 32'd68, 32'd110};

        repeat (3) @(negedge clk);
        chk_quiet("rst");
        rst = 1'b0;

        // Basic sequence
        load(0, 32'd2);
        load(1, 32'd2);
        launch(0, 8);
        wait_idle();
        for (int j = 0; j < 8; j++) peek($sformatf("basic_m%0d", j + 2),
                                         AW'(j + 2), exp_seq[j]);
        chk("basic_lat", 32'(done_cyc - e_cyc), 32'd32);
        chk("basic_done_n", 32'(done_n), 32'd1);
        chk("basic_wr_n", 32'(wr_n), 32'd8);
        chk("basic_ovf", 32'(ovf), 32'd0);
        chk("basic_d1", data1, 32'd42);
        chk("basic_d2", data2, 32'd68);

        // Zero length
        launch(0, 0);
        wait_idle();
        chk("zero_lat", 32'(done_cyc - e_cyc), 32'd0);
        chk("zero_done_n", 32'(done_n), 32'd1);
        chk("zero_wr_n", 32'(wr_n), 32'd0);
        peek("zero_m2", 2, 32'd4);
        peek("zero_m3", 3, 32'd6);

        // Address wrap
        load(62, 32'd1);
        load(63, 32'd1);
        launch(62, 2);
        wait_idle();
        peek("wrap_m0", 0, 32'd2);
        peek("wrap_m1", 1, 32'd3);
        chk("wrap_wr_n", 32'(wr_n), 32'd2);

        // Overflow and clear on next start
        load(0, 32'hFFFF_FFFF);
        load(1, 32'd1);
        launch(0, 1);
        wait_idle();
        peek("ovf_m2", 2, 32'd0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_d1", data1, 32'hFFFF_FFFF);
        chk("ovf_d2", data2, 32'd1);
        launch(0, 0);
        wait_idle();
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Start while busy, pulsed in cycle E+5
        load(0, 32'd1);
        load(1, 32'd1);
        launch(0, 3);
        repeat (4) @(negedge clk);
        start = 1'b1; base = 10; len = 5;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("busy_wr_n", 32'(wr_n), 32'd3);
        chk("busy_done_n", 32'(done_n), 32'd1);
        chk("busy_lat", 32'(done_cyc - e_cyc), 32'd12);
        chk("busy_idle", 32'(busy), 32'd0);
        peek("busy_m4", 4, 32'd5);

        // Mid-run reset in the WR cycle of element 2
        load(0, 32'd1);
        load(1, 32'd2);
        load(3, 32'hDEAD);
        launch(0, 4);
        repeat (7) @(negedge clk);
        chk("mrst_in_wr", 32'(ram_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_quiet("mrst");
        chk("mrst_done_n", 32'(done_n), 32'd0);
        chk("mrst_wr_n", 32'(wr_n), 32'd1);
        peek("mrst_m2", 2, 32'd3);
        peek("mrst_m3", 3, 32'hDEAD);
        launch(0, 2);
        wait_idle();
        peek("after_m2", 2, 32'd3);
        peek("after_m3", 3, 32'd5);
        chk("after_done_n", 32'(done_n), 32'd1);
        chk("after_lat", 32'(done_cyc - e_cyc), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
